// File: rtl/mem_io_responder_if.sv
// CPU-side byte bus between the memory controller (master) and the RAM/IO responder (slave).
interface mem_io_responder_if;
   logic        rdy_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;

   modport master (output rdy_in, mem_a, mem_wr, mem_dout, input  mem_din);
   modport slave  (input  rdy_in, mem_a, mem_wr, mem_dout, output mem_din);
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus I/O window (output FIFO, input FIFO, cycle counter, stop flag)
// answering the CPU memory bus with a 1-cycle registered read.
module mem_io_responder #(
   parameter int RAM_AW      = 17,
   parameter int OFIFO_DEPTH = 16,
   parameter int IFIFO_DEPTH = 16
) (
   input  logic                clk_in,
   input  logic                rst_in,
   mem_io_responder_if.slave   bus,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   output logic                program_stop,
   output logic                tx_overflow
);

   localparam int OAW = $clog2(OFIFO_DEPTH);
   localparam int IAW = $clog2(IFIFO_DEPTH);
   localparam logic [OAW:0] O_ONE = 1;
   localparam logic [IAW:0] I_ONE = 1;

   typedef enum logic {SRC_IO, SRC_RAM} din_src_e;

   logic [7:0]  ram [2**RAM_AW];
   logic [7:0]  ofifo_mem [OFIFO_DEPTH];
   logic [7:0]  ifo_mem [IFIFO_DEPTH];

   logic [OAW:0] o_wptr, o_rptr;
   logic [IAW:0] i_wptr, i_rptr;
   logic [31:0]  counter, snapshot;
   logic [7:0]   ram_q, io_q, io_next, o_push_data;
   din_src_e     din_src;

   logic is_io, ram_we, ram_re, io_wr, io_rd;
   logic sel_data, sel_clk, sel_snap1, sel_snap2, sel_snap3;
   logic o_empty, o_full, o_push_req, o_push, o_pop, o_drop;
   logic i_empty, i_full, i_push, i_pop;
   logic unused_addr_bits;

   assign unused_addr_bits = ^bus.mem_a[31:18];

   // NOTE: every signal gets a default before any branch so no latch is inferred.
   always_comb begin
      is_io     = (bus.mem_a[17:16] == 2'b11);
      ram_we    = bus.rdy_in &  bus.mem_wr & ~is_io;
      ram_re    = bus.rdy_in & ~bus.mem_wr & ~is_io;
      io_wr     = bus.rdy_in &  bus.mem_wr &  is_io;
      io_rd     = bus.rdy_in & ~bus.mem_wr &  is_io;
      sel_data  = (bus.mem_a[15:0] == 16'h0000);
      sel_clk   = (bus.mem_a[15:0] == 16'h0004);
      sel_snap1 = (bus.mem_a[15:0] == 16'h0005);
      sel_snap2 = (bus.mem_a[15:0] == 16'h0006);
      sel_snap3 = (bus.mem_a[15:0] == 16'h0007);
   end

   // Pointers carry one extra wrap bit: equal = empty, only MSB differs = full.
   always_comb begin
      o_empty     = (o_wptr == o_rptr);
      o_full      = (o_wptr[OAW] != o_rptr[OAW]) && (o_wptr[OAW-1:0] == o_rptr[OAW-1:0]);
      i_empty     = (i_wptr == i_rptr);
      i_full      = (i_wptr[IAW] != i_rptr[IAW]) && (i_wptr[IAW-1:0] == i_rptr[IAW-1:0]);
      o_push_req  = io_wr & ((sel_data & (bus.mem_dout != 8'h00)) | sel_clk);
      o_push_data = sel_clk ? 8'h00 : bus.mem_dout;
      o_pop       = ~o_empty & tx_ready;
      o_push      = o_push_req & (~o_full | o_pop);
      o_drop      = o_push_req & o_full & ~o_pop;
      i_push      = rx_valid & ~i_full;
      i_pop       = io_rd & sel_data & ~i_empty;
   end

   always_comb begin
      io_next = 8'h00;
      if (sel_data && !i_empty) io_next = ifo_mem[i_rptr[IAW-1:0]];
      else if (sel_clk)         io_next = counter[7:0];
      else if (sel_snap1)       io_next = snapshot[15:8];
      else if (sel_snap2)       io_next = snapshot[23:16];
      else if (sel_snap3)       io_next = snapshot[31:24];
   end

   // NOTE: storage arrays are not reset; writes are gated by rst_in so a write
   // in flight when reset asserts never lands.
   always_ff @(posedge clk_in) begin
      if (ram_we && rst_in) ram[bus.mem_a[RAM_AW-1:0]] <= bus.mem_dout;
      if (ram_re)           ram_q <= ram[bus.mem_a[RAM_AW-1:0]];
      if (o_push && rst_in) ofifo_mem[o_wptr[OAW-1:0]] <= o_push_data;
      if (i_push && rst_in) ifo_mem[i_wptr[IAW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         o_wptr       <= '0;
         o_rptr       <= '0;
         i_wptr       <= '0;
         i_rptr       <= '0;
         counter      <= '0;
         snapshot     <= '0;
         io_q         <= 8'h00;
         din_src      <= SRC_IO;
         program_stop <= 1'b0;
         tx_overflow  <= 1'b0;
      end else begin
         counter <= counter + 32'd1;
         if (o_push) o_wptr <= o_wptr + O_ONE;
         if (o_pop)  o_rptr <= o_rptr + O_ONE;
         if (i_push) i_wptr <= i_wptr + I_ONE;
         if (i_pop)  i_rptr <= i_rptr + I_ONE;
         if (o_drop) tx_overflow <= 1'b1;
         if (io_wr && sel_clk) program_stop <= 1'b1;
         if (io_rd && sel_clk) snapshot <= counter;
         // With rdy_in low both read-data sources hold, so mem_din holds.
         if (bus.rdy_in) begin
            if (bus.mem_wr) begin
               din_src <= SRC_IO;
               io_q    <= 8'h00;
            end else if (is_io) begin
               din_src <= SRC_IO;
               io_q    <= io_next;
            end else begin
               din_src <= SRC_RAM;
            end
         end
      end
   end

   assign bus.mem_din = (din_src == SRC_RAM) ? ram_q : io_q;
   assign tx_valid    = ~o_empty;
   assign tx_data     = ofifo_mem[o_rptr[OAW-1:0]];
   assign rx_ready    = ~i_full;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed plus random stimulus for mem_io_responder, checked against a
// transaction-level model built from queues, an associative RAM and a cycle count.
module tb_mem_io_responder;
   localparam int OFD = 16;
   localparam int IFD = 16;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [7:0] tx_data, rx_data;
   logic       tx_valid, tx_ready, rx_valid, rx_ready, program_stop, tx_overflow;

   mem_io_responder_if bus();

   mem_io_responder #(.RAM_AW(17), .OFIFO_DEPTH(OFD), .IFIFO_DEPTH(IFD)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .bus(bus),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .program_stop(program_stop), .tx_overflow(tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   int compared = 0;
   int mismatched = 0;

   bit [7:0]  ram_m [int];
   bit [7:0]  oq [$];
   bit [7:0]  iq [$];
   bit [31:0] cnt_m, snap_m;
   bit [7:0]  din_m;
   bit        stop_m, ovf_m;
   bit [31:0] pool [8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".mem_din"}, {24'h0, bus.mem_din}, {24'h0, din_m});
      check({tag, ".tx_valid"}, {31'h0, tx_valid}, {31'h0, oq.size() != 0});
      if (oq.size() != 0) check({tag, ".tx_data"}, {24'h0, tx_data}, {24'h0, oq[0]});
      check({tag, ".rx_ready"}, {31'h0, rx_ready}, {31'h0, iq.size() < IFD});
      check({tag, ".program_stop"}, {31'h0, program_stop}, {31'h0, stop_m});
      check({tag, ".tx_overflow"}, {31'h0, tx_overflow}, {31'h0, ovf_m});
   endtask

   // Entered just after a falling edge; consumes exactly one rising edge.
   task automatic step(input string tag, input bit rdy, input bit [31:0] a, input bit wr,
                       input bit [7:0] d, input bit txr, input bit rxv, input bit [7:0] rxd);
      bit        tx_pop, rx_push, push_req, is_io;
      bit [7:0]  push_d;
      int        idx;
      bus.rdy_in = rdy; bus.mem_a = a; bus.mem_wr = wr; bus.mem_dout = d;
      tx_ready = txr; rx_valid = rxv; rx_data = rxd;

      tx_pop   = (oq.size() != 0) && txr;
      rx_push  = rxv && (iq.size() < IFD);
      push_req = 1'b0;
      push_d   = 8'h00;
      is_io    = (a[17:16] == 2'b11);
      idx      = int'(a[16:0]);
      if (rdy) begin
         if (wr) begin
            din_m = 8'h00;
            if (!is_io) ram_m[idx] = d;
            else if (a[15:0] == 16'h0000 && d != 8'h00) begin push_req = 1'b1; push_d = d; end
            else if (a[15:0] == 16'h0004) begin stop_m = 1'b1; push_req = 1'b1; end
         end else if (!is_io) begin
            din_m = ram_m.exists(idx) ? ram_m[idx] : 8'h00;
         end else begin
            case (a[15:0])
               16'h0000: din_m = (iq.size() != 0) ? iq.pop_front() : 8'h00;
               16'h0004: begin snap_m = cnt_m; din_m = cnt_m[7:0]; end
               16'h0005: din_m = snap_m[15:8];
               16'h0006: din_m = snap_m[23:16];
               16'h0007: din_m = snap_m[31:24];
               default:  din_m = 8'h00;
            endcase
         end
      end
      if (tx_pop) void'(oq.pop_front());
      if (push_req) begin
         if (oq.size() < OFD) oq.push_back(push_d);
         else ovf_m = 1'b1;
      end
      if (rx_push) iq.push_back(rxd);
      cnt_m++;

      @(posedge clk_in);
      #1;
      check_outputs(tag);
      @(negedge clk_in);
   endtask

   // Asserts reset at the current falling edge and releases it two edges later.
   task automatic apply_reset();
      rst_in = 1'b0;
      oq.delete(); iq.delete();
      cnt_m = 0; snap_m = 0; din_m = 8'h00; stop_m = 1'b0; ovf_m = 1'b0;
      #1;
      check_outputs("reset");
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      bit [7:0] b [4];
      bus.rdy_in = 1'b0; bus.mem_a = '0; bus.mem_wr = 1'b0; bus.mem_dout = '0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      @(negedge clk_in);
      apply_reset();

      // RAM write then read, 1-cycle latency, top address
      step("ram_wr", 1, 32'h0000_0010, 1, 8'hA5, 0, 0, 0);
      step("ram_rd", 1, 32'h0000_0010, 0, 8'h00, 0, 0, 0);
      step("ram_hold", 0, 32'h0001_FFFF, 0, 8'h00, 0, 0, 0);
      step("ram_wr_top", 1, 32'h0001_FFFF, 1, 8'h3C, 0, 0, 0);
      step("ram_rd_top", 1, 32'h0001_FFFF, 0, 8'h00, 0, 0, 0);

      pool[0] = 32'h0001_FFFF;
      for (int i = 1; i < 8; i++) pool[i] = 32'h20 + $urandom_range(0, 32'h1FFD0);
      for (int i = 0; i < 8; i++) step("ram_fill", 1, pool[i], 1, 8'($urandom), 0, 0, 0);

      // rdy_in gating on an output-FIFO write
      for (int i = 0; i < 5; i++) step("gate_off", 0, 32'h0003_0000, 1, 8'h41, 0, 0, 0);
      step("gate_on", 1, 32'h0003_0000, 1, 8'h41, 0, 0, 0);
      step("gate_drain", 0, 32'h0, 0, 8'h00, 1, 0, 0);

      // Output FIFO zero filter, overflow, ordered drain
      step("ofifo_zero", 1, 32'h0003_0000, 1, 8'h00, 0, 0, 0);
      for (int i = 1; i <= 17; i++) step("ofifo_fill", 1, 32'h0003_0000, 1, 8'(i), 0, 0, 0);
      step("ofifo_fullpp", 1, 32'h0003_0000, 1, 8'h77, 1, 0, 0);
      for (int i = 0; i < 17; i++) step("ofifo_drain", 0, 32'h0, 0, 8'h00, 1, 0, 0);

      // Program stop pushes a zero byte
      step("stop_wr", 1, 32'h0003_0004, 1, 8'h5A, 0, 0, 0);
      step("stop_drain", 0, 32'h0, 0, 8'h00, 1, 0, 0);

      // Input FIFO basic and full/empty corner cases
      step("rx_push", 0, 32'h0, 0, 8'h00, 0, 1, 8'h55);
      step("rx_push", 0, 32'h0, 0, 8'h00, 0, 1, 8'h66);
      for (int i = 0; i < 3; i++) step("rx_read", 1, 32'h0003_0000, 0, 8'h00, 0, 0, 0);
      step("rx_empty_pp", 1, 32'h0003_0000, 0, 8'h00, 0, 1, 8'h99);
      for (int i = 0; i < 17; i++) step("rx_fill", 0, 32'h0, 0, 8'h00, 0, 1, 8'(8'hB0 + i));
      step("rx_full_pp", 1, 32'h0003_0000, 0, 8'h00, 0, 1, 8'hEE);
      for (int i = 0; i < 17; i++) step("rx_drain", 1, 32'h0003_0000, 0, 8'h00, 0, 0, 0);
      step("io_other", 1, 32'h0003_0008, 0, 8'h00, 0, 0, 0);

      // Random traffic across RAM pool and every IO register
      for (int i = 0; i < 400; i++) begin
         bit [31:0] a;
         bit        wr;
         case ($urandom_range(0, 5))
            0, 1:    a = pool[$urandom_range(0, 7)];
            2:       a = 32'h0003_0000;
            3:       a = 32'h0003_0004 + $urandom_range(0, 3);
            4:       a = 32'h0003_0008 + $urandom_range(0, 32'hFFF0);
            default: a = 32'h0003_0000;
         endcase
         wr = ($urandom_range(0, 3) == 0);
         if (a == 32'h0003_0004 && wr && $urandom_range(0, 3) != 0) wr = 1'b0;
         step("random", $urandom_range(0, 3) != 0, a, wr, 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
      end

      // Reset during a RAM write: the write is aborted
      bus.rdy_in = 1'b1; bus.mem_a = 32'h0000_0010; bus.mem_wr = 1'b1; bus.mem_dout = 8'hEE;
      rx_valid = 1'b1; rx_data = 8'h12;
      apply_reset();

      // Counter restarts at 0; read snapshot bytes on consecutive cycles
      idle("cnt_idle", 99);
      step("cnt_rd0", 1, 32'h0003_0004, 0, 8'h00, 0, 0, 0); b[0] = bus.mem_din;
      step("cnt_rd1", 1, 32'h0003_0005, 0, 8'h00, 0, 0, 0); b[1] = bus.mem_din;
      step("cnt_rd2", 1, 32'h0003_0006, 0, 8'h00, 0, 0, 0); b[2] = bus.mem_din;
      step("cnt_rd3", 1, 32'h0003_0007, 0, 8'h00, 0, 0, 0); b[3] = bus.mem_din;
      check("snapshot", {b[3], b[2], b[1], b[0]}, snap_m);
      step("cnt_rd5_again", 1, 32'h0003_0005, 0, 8'h00, 0, 0, 0);
      step("post_rst_ram", 1, 32'h0000_0010, 0, 8'h00, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide RAM/IO bus (mem_a, mem_wr, mem_dout, mem_din). It sits opposite the CPU's memory controller.
- Contains 128 KB of byte RAM with a 1-cycle registered read.
- Decodes the I/O window (mem_a[17:16]==2'b11) into:
  - a UART-side output FIFO,
  - a UART-side input FIFO,
  - a free-running cycle counter,
  - a program-stop flag.
- Used as the simulation/FPGA memory model behind the CPU top.

Parameters:
RAM_AW, 17, RAM byte-address width (2^17 = 128 KB); RAM indexed by mem_a[RAM_AW-1:0]
OFIFO_DEPTH, 16, output FIFO entries (power of 2, >=2)
IFIFO_DEPTH, 16, input FIFO entries (power of 2, >=2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  bus qualifier; when low no access is performed
mem_a  input  32  byte address from CPU (only 17:0 decoded)
mem_wr  input  1  1 = write, 0 = read
mem_dout  input  8  write data from CPU
mem_din  output  8  read data to CPU, registered
tx_data  output  8  output FIFO head byte
tx_valid  output  1  output FIFO non-empty
tx_ready  input  1  consumer accepts tx_data this cycle
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  input FIFO not full
program_stop  output  1  sticky; set by write to 0x30004
tx_overflow  output  1  sticky; set when a byte is dropped on a full output FIFO

Behaviour:
- Reset (rst_in low, async):
  - Outputs: mem_din=0, program_stop=0, tx_overflow=0.
  - FIFOs empty: tx_valid=0, rx_ready=1.
  - Cycle counter=0, snapshot=0.
  - RAM contents are not reset.
  - Reset mid-access aborts the access; no write completes.
- Access: a cycle is an access iff rdy_in=1. IO iff mem_a[17:16]==2'b11, otherwise RAM.
- rdy_in=0: no RAM write, no FIFO push/pop from the bus side, mem_din holds. The counter and the tx/rx handshakes continue.
- RAM write: mem_dout is stored at the rising edge; mem_din after a write cycle = 0x00.
- RAM read: mem_din = RAM[addr] on the next cycle (1-cycle latency).
- Back-to-back read-after-write to the same address returns the new value.
- IO write 0x30000:
  - Data != 0: push to the output FIFO.
  - Data == 0: ignored.
  - Push while full (and no same-cycle pop): byte dropped, tx_overflow set.
- IO write 0x30004:
  - Sets program_stop.
  - Pushes 0x00 into the output FIFO; this push bypasses the zero filter and the overflow rule is the same.
- IO read 0x30000:
  - Pops the input FIFO; mem_din next cycle = popped byte.
  - If empty: mem_din = 0x00 and no pop.
- IO read 0x30004:
  - Latches snapshot = current counter value.
  - mem_din next cycle = counter[7:0].
- IO read 0x30005/6/7: mem_din = snapshot[15:8] / [23:16] / [31:24]; no re-latch.
- Other IO addresses: reads return 0x00, writes are ignored.
- Cycle counter: 32-bit, +1 every clock after reset regardless of rdy_in, wraps 0xFFFFFFFF -> 0.
- Output FIFO:
  - tx_valid = !empty; tx_data = head (combinational from the storage array).
  - Pop on tx_valid & tx_ready.
  - Simultaneous push and pop when full: both occur, occupancy unchanged, no overflow.
  - Simultaneous push and pop when empty: push only.
- Input FIFO:
  - rx_ready = !full; push on rx_valid & rx_ready.
  - Simultaneous bus pop and rx push when full: the pop makes room but rx_ready is already low, so no push that cycle.
  - Simultaneous pop and push when empty: the pop returns 0x00 and the push is kept.
- FIFO pointers: log2(depth)+1 bits; full/empty derived from the MSB compare; wrap-around at depth.
- program_stop and tx_overflow clear only on reset.

Test Plan:
- RAM: write 0xA5 to 0x00010 (rdy_in=1), then read 0x00010 -> mem_din=0xA5 exactly 1 cycle after the read address; read 0x1FFFF after writing 0x3C -> 0x3C.
- rdy_in gating: hold mem_a=0x30000, mem_wr=1, mem_dout=0x41 with rdy_in=0 for 5 cycles -> no push (tx_valid=0); then rdy_in=1 for 1 cycle -> exactly one byte 0x41 at tx_data.
- Output FIFO: tx_ready=0, write 0x30000 with 0x00 -> ignored; write 17 nonzero bytes 0x01..0x11 -> FIFO holds 0x01..0x10 and tx_overflow=1; then tx_ready=1 -> drains 0x01..0x10 in order.
- Stop: write 0x30004 (any data) -> program_stop=1 the next cycle and a 0x00 byte appears on tx_data.
- Counter: 100 cycles after reset release, read 0x30004..0x30007 on consecutive cycles -> bytes reconstruct the snapshot taken at the 0x30004 read (value 100 ± the fixed bench offset) and remain constant across the 4 reads.
- Input FIFO and reset: push 0x55, 0x66 via rx; read 0x30000 twice -> 0x55, 0x66; third read -> 0x00. Assert rst_in low mid-burst -> mem_din=0, FIFOs empty, counter restarts at 0.
